mash_combiner: RTL and testbench



---
 rtl/sdm_pkg.sv | 16 +
 rtl/mash_diff.sv | 41 ++++
 rtl/mash_combiner.sv | 97 +++++++++
 tb/tb_mash_combiner.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sdm_pkg.sv
// Shared sigma-delta modulator types and constants.
// Used by the MASH 1-1-1 combiner and its differentiator chains.
package sdm_pkg;

    localparam int MASH_Y_W    = 4;
    localparam int MASH_Y_MIN  = -3;
    localparam int MASH_Y_MAX  = 4;
    localparam int MASH_WARMUP = 2;

    typedef logic signed [MASH_Y_W-1:0] mash_y_t;

    function automatic mash_y_t y_of(input logic b);
        return {{(MASH_Y_W-1){1'b0}}, b};
    endfunction

endpackage

// File: rtl/mash_diff.sv
// Single-carry delay / differentiator chain of order 0, 1 or 2.
// Chain clears while En is low so fractional mode restarts cleanly.
module mash_diff
    import sdm_pkg::*;
#(
    parameter int ORDER = 0
) (
    input  logic    Clk,
    input  logic    reset,
    input  logic    En,
    input  logic    c,
    output mash_y_t d
);

    logic c_d1;
    logic c_d2;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            c_d1 <= 1'b0;
            c_d2 <= 1'b0;
        end else if (!En) begin
            c_d1 <= 1'b0;
            c_d2 <= 1'b0;
        end else begin
            c_d1 <= c;
            c_d2 <= c_d1;
        end
    end

    generate
        if (ORDER == 0) begin : g_o0
            assign d = y_of(c_d2);
        end else if (ORDER == 1) begin : g_o1
            assign d = y_of(c_d1) - y_of(c_d2);
        end else begin : g_o2
            assign d = y_of(c) - (y_of(c_d1) <<< 1) + y_of(c_d2);
        end
    endgenerate

endmodule

// File: rtl/mash_combiner.sv
// MASH 1-1-1 noise-cancellation and registered divide-ratio output.
// Define MASH_SAT_EN to clamp the ratio to [DIV_MIN, DIV_MAX].
module mash_combiner
    import sdm_pkg::*;
#(
    parameter int W       = 9,
    parameter int DIV_MIN = 16,
    parameter int DIV_MAX = 511
) (
    input  logic         Clk,
    input  logic         reset,
    input  logic         En,
    input  logic         C1,
    input  logic         C2,
    input  logic         C3,
    input  logic [W-1:0] N_int,
    output logic [W-1:0] Out_Div,
    output logic         Out_Valid,
    output logic         Sat_Flag
);

    mash_y_t d1, d2, d3, y;
    logic [1:0] wcnt;
    logic [W-1:0] div_next;

    mash_diff #(.ORDER(0)) u_d1 (
        .Clk(Clk), .reset(reset), .En(En), .c(C1), .d(d1)
    );
    mash_diff #(.ORDER(1)) u_d2 (
        .Clk(Clk), .reset(reset), .En(En), .c(C2), .d(d2)
    );
    mash_diff #(.ORDER(2)) u_d3 (
        .Clk(Clk), .reset(reset), .En(En), .c(C3), .d(d3)
    );

    assign y = d1 + d2 + d3;

`ifdef MASH_SAT_EN
    localparam logic signed [W+1:0] LO = (W+2)'(DIV_MIN);
    localparam logic signed [W+1:0] HI = (W+2)'(DIV_MAX);

    logic signed [W+1:0] s;
    logic sat_next;
    logic sat_q;

    assign s = signed'({2'b00, N_int})
             + {{(W+2-MASH_Y_W){y[MASH_Y_W-1]}}, y};

    always_comb begin
        sat_next = 1'b0;
        div_next = s[W-1:0];
        if (s < LO) begin
            sat_next = 1'b1;
            div_next = LO[W-1:0];
        end else if (s > HI) begin
            sat_next = 1'b1;
            div_next = HI[W-1:0];
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset)
            sat_q <= 1'b0;
        else if (!En)
            sat_q <= 1'b0;
        else
            sat_q <= sat_next;
    end

    assign Sat_Flag = sat_q;
`else
    // Low W bits of the wide sum are all that survive the wrap.
    assign div_next = N_int
                    + {{(W-MASH_Y_W){y[MASH_Y_W-1]}}, y};
    assign Sat_Flag = 1'b0;
`endif

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            Out_Div   <= '0;
            Out_Valid <= 1'b0;
            wcnt      <= '0;
        end else if (!En) begin
            Out_Div   <= N_int;
            Out_Valid <= 1'b0;
            wcnt      <= '0;
        end else begin
            Out_Div   <= div_next;
            Out_Valid <= (wcnt == 2'(MASH_WARMUP));
            if (wcnt != 2'(MASH_WARMUP))
                wcnt <= wcnt + 2'd1;
            assert (int'(y) >= MASH_Y_MIN && int'(y) <= MASH_Y_MAX);
            assert (DIV_MIN <= DIV_MAX);
        end
    end

endmodule

// File: tb/tb_mash_combiner.sv
// Directed bench for mash_combiner: vector table plus reset,
// enable and long-run mean sequences.
module tb_mash_combiner;

    localparam int W = 9;

    logic Clk = 1'b0;
    logic reset = 1'b0;
    logic En = 1'b0;
    logic C1 = 1'b0;
    logic C2 = 1'b0;
    logic C3 = 1'b0;
    logic [W-1:0] N_int = '0;
    logic [W-1:0] Out_Div;
    logic Out_Valid;
    logic Sat_Flag;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic en;
        logic c1;
        logic c2;
        logic c3;
        int   n;
        int   div;
        logic valid;
        logic sat;
    } vec_t;

    vec_t vq[$];

    mash_combiner #(.W(W), .DIV_MIN(16), .DIV_MAX(511)) dut (
        .Clk(Clk), .reset(reset), .En(En),
        .C1(C1), .C2(C2), .C3(C3), .N_int(N_int),
        .Out_Div(Out_Div), .Out_Valid(Out_Valid),
        .Sat_Flag(Sat_Flag)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic void add(input logic en, input logic c1,
                                input logic c2, input logic c3,
                                input int n, input int div,
                                input logic valid, input logic sat);
        vec_t v;
        v.en = en; v.c1 = c1; v.c2 = c2; v.c3 = c3;
        v.n = n; v.div = div; v.valid = valid; v.sat = sat;
        vq.push_back(v);
    endfunction

    initial begin
        logic [24:0] s1, s2, s3;
        logic [23:0] a1, a2, a3;
        int sum, pulses, diff;

        // table: integer start, baseline warm-up, impulses, clamp, En drop
        add(0, 0, 0, 0, 40, 40, 0, 0);
        for (int i = 0; i < 10; i++)
            add(1, 0, 0, 0, 40, 40, (i >= 2), 0);
        add(1, 0, 0, 1, 40, 41, 1, 0);
        add(1, 0, 0, 0, 40, 38, 1, 0);
        add(1, 0, 0, 0, 40, 41, 1, 0);
        add(1, 0, 0, 0, 40, 40, 1, 0);
        add(1, 0, 1, 0, 40, 40, 1, 0);
        add(1, 0, 0, 0, 40, 41, 1, 0);
        add(1, 0, 0, 0, 40, 39, 1, 0);
        add(1, 0, 0, 0, 40, 40, 1, 0);
        add(1, 1, 0, 0, 40, 40, 1, 0);
        add(1, 0, 0, 0, 40, 40, 1, 0);
        add(1, 0, 0, 0, 40, 41, 1, 0);
        add(1, 0, 0, 0, 40, 40, 1, 0);
        add(1, 0, 0, 0, 16, 16, 1, 0);
        add(1, 0, 0, 1, 16, 17, 1, 0);
`ifdef MASH_SAT_EN
        add(1, 0, 0, 0, 16, 16, 1, 1);
`else
        add(1, 0, 0, 0, 16, 14, 1, 0);
`endif
        add(1, 0, 0, 0, 16, 17, 1, 0);
        add(1, 0, 0, 0, 16, 16, 1, 0);
        add(1, 0, 0, 1, 40, 41, 1, 0);
        add(0, 0, 0, 0, 40, 40, 0, 0);
        add(1, 0, 0, 0, 40, 40, 0, 0);
        add(1, 0, 0, 0, 40, 40, 0, 0);
        add(1, 0, 0, 0, 40, 40, 1, 0);

        #12;
        chk("reset_div", Out_Div, 0);
        chk("reset_valid", Out_Valid, 0);
        chk("reset_sat", Sat_Flag, 0);
        @(posedge Clk);
        #1 reset = 1'b1;

        foreach (vq[i]) begin
            En = vq[i].en;
            C1 = vq[i].c1;
            C2 = vq[i].c2;
            C3 = vq[i].c3;
            N_int = W'(vq[i].n);
            step();
            chk($sformatf("vec%0d_div", i), Out_Div, vq[i].div);
            chk($sformatf("vec%0d_valid", i), Out_Valid, vq[i].valid);
            chk($sformatf("vec%0d_sat", i), Sat_Flag, vq[i].sat);
        end

        // asynchronous reset mid-stream
        En = 1'b1; C3 = 1'b1; N_int = 40;
        step();
        chk("pre_rst_div", Out_Div, 41);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_div", Out_Div, 0);
        chk("async_rst_valid", Out_Valid, 0);
        chk("async_rst_sat", Sat_Flag, 0);
        @(posedge Clk);
        #1 reset = 1'b1;
        En = 1'b0; C3 = 1'b0; N_int = 25;
        step();
        chk("int_div", Out_Div, 25);
        chk("int_valid", Out_Valid, 0);
        En = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("warm%0d_div", k), Out_Div, 25);
            chk($sformatf("warm%0d_valid", k), Out_Valid, (k == 2));
        end

        // long-run mean with a three-accumulator model at 0.25
        En = 1'b0; N_int = 40;
        step();
        En = 1'b1;
        a1 = '0; a2 = '0; a3 = '0;
        sum = 0; pulses = 0;
        for (int k = 0; k < 4096; k++) begin
            s1 = {1'b0, a1} + 25'h400000;
            a1 = s1[23:0];
            s2 = {1'b0, a2} + {1'b0, a1};
            a2 = s2[23:0];
            s3 = {1'b0, a3} + {1'b0, a2};
            a3 = s3[23:0];
            C1 = s1[24];
            C2 = s2[24];
            C3 = s3[24];
            pulses += int'(s1[24]);
            step();
            sum += int'(Out_Div) - 40;
        end
        diff = sum - pulses;
        checks++;
        if (diff > 4 || diff < -4 || pulses != 1024) begin
            failures++;
            $display("FAIL mean: sum=%0d pulses=%0d required pulses=1024 within 4",
                     sum, pulses);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
